// File: rtl/nrisc_exec_stage.sv
// Three-cycle execute stage: operand fetch to the ULA, result capture, writeback.
// Holds the 8-entry register file and the architectural flag register.
module nrisc_exec_stage #(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [3:0]     op,
    input  logic [2:0]     rd,
    input  logic [2:0]     rs1,
    input  logic [2:0]     rs2,
    input  logic           inc_in,
    input  logic           ld_en,
    input  logic [2:0]     ld_addr,
    input  logic [TAM-1:0] ld_data,
    input  logic [2:0]     obs_addr,
    output logic [TAM-1:0] obs_data,
    output logic [TAM-1:0] ULA_A,
    output logic [TAM-1:0] ULA_B,
    output logic [3:0]     ULA_ctrl,
    output logic           incdec,
    input  logic [TAM-1:0] ULA_OUT,
    input  logic [2:0]     ULA_flags,
    output logic [2:0]     flags,
    output logic           wb_valid,
    output logic           op_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [TAM-1:0] rf_q [8];
    logic [TAM-1:0] rf_d [8];
    logic [TAM-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]     ctrl_q, ctrl_d;
    logic           incdec_q, incdec_d;
    logic [2:0]     rd_q, rd_d;
    logic [TAM-1:0] res_q, res_d;
    logic [2:0]     fhold_q, fhold_d;
    logic [2:0]     flags_q, flags_d;
    logic           wb_valid_q, wb_valid_d;
    logic           op_err_q, op_err_d;

    logic handshake;
    logic op_legal;
    logic wb_write;

    assign instr_ready = (state_q == S_IDLE);
    assign handshake   = instr_valid & instr_ready;

    always_comb begin
        op_legal = 1'b0;
        case (ctrl_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1101, 4'b1110: op_legal = 1'b1;
            default:          op_legal = 1'b0;
        endcase
    end

    assign wb_write = (state_q == S_WB) & op_legal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (handshake) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operands sample rf_q, so same-edge loads or writebacks are never bypassed.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        incdec_d = incdec_q;
        rd_d     = rd_q;
        if (handshake) begin
            a_d      = rf_q[rs1];
            b_d      = rf_q[rs2];
            ctrl_d   = op;
            incdec_d = (op == 4'b0000 || op == 4'b0001) ? inc_in : 1'b0;
            rd_d     = rd;
        end
    end

    always_comb begin
        res_d   = res_q;
        fhold_d = fhold_q;
        if (state_q == S_EXEC) begin
            res_d   = ULA_OUT;
            fhold_d = ULA_flags;
        end
    end

    // Writeback is applied after the load port so it wins on an address collision.
    always_comb begin
        rf_d = rf_q;
        if (ld_en)
            rf_d[ld_addr] = ld_data;
        if (wb_write)
            rf_d[rd_q] = res_q;
    end

    always_comb begin
        flags_d    = wb_write ? fhold_q : flags_q;
        wb_valid_d = wb_write;
        op_err_d   = (state_q == S_WB) & ~op_legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rf_q       <= '{default: '0};
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            incdec_q   <= 1'b0;
            rd_q       <= '0;
            res_q      <= '0;
            fhold_q    <= '0;
            flags_q    <= '0;
            wb_valid_q <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctrl_q     <= ctrl_d;
            incdec_q   <= incdec_d;
            rd_q       <= rd_d;
            res_q      <= res_d;
            fhold_q    <= fhold_d;
            flags_q    <= flags_d;
            wb_valid_q <= wb_valid_d;
            op_err_q   <= op_err_d;
        end
    end

    assign obs_data = rf_q[obs_addr];
    assign ULA_A    = a_q;
    assign ULA_B    = b_q;
    assign ULA_ctrl = ctrl_q;
    assign incdec   = incdec_q;
    assign flags    = flags_q;
    assign wb_valid = wb_valid_q;
    assign op_err   = op_err_q;

endmodule

// File: tb/tb_nrisc_exec_stage.sv
// Bench for nrisc_exec_stage: behavioural ULA stub plus a register/flag model
// updated per retired instruction.
`timescale 1ns/1ps
module tb_nrisc_exec_stage;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [3:0]   op;
    logic [2:0]   rd, rs1, rs2;
    logic         inc_in;
    logic         ld_en;
    logic [2:0]   ld_addr;
    logic [W-1:0] ld_data;
    logic [2:0]   obs_addr;
    logic [W-1:0] obs_data;
    logic [W-1:0] ULA_A, ULA_B;
    logic [3:0]   ULA_ctrl;
    logic         incdec;
    logic [W-1:0] ULA_OUT;
    logic [2:0]   ULA_flags;
    logic [2:0]   flags;
    logic         wb_valid, op_err;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] R [8];
    logic [2:0]   mflags;

    always #10 clk = ~clk;

    nrisc_exec_stage #(.TAM(W)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .inc_in(inc_in),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .obs_addr(obs_addr), .obs_data(obs_data),
        .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_ctrl(ULA_ctrl), .incdec(incdec),
        .ULA_OUT(ULA_OUT), .ULA_flags(ULA_flags),
        .flags(flags), .wb_valid(wb_valid), .op_err(op_err)
    );

    // Returns {neg, zero, carry, result}
    function automatic logic [W+2:0] ula_f(input logic [3:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic inc);
        logic [W-1:0] r;
        logic c;
        int   t;
        c = 1'b0;
        case (o)
            4'd0:  begin t = int'(a) + int'(b) + int'(inc); r = W'(t); c = (t > 65535); end
            4'd1:  begin t = int'(a) - int'(b) - int'(inc); r = W'(t); c = (t < 0); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  begin r = a << 1; c = a[W-1]; end
            4'd7:  begin r = a >> 1; c = a[0]; end
            4'd13: r = a + 16'd1;
            4'd14: r = a - 16'd1;
            default: r = a ^ b ^ 16'h5A5A;
        endcase
        return {r[W-1], (r == '0), c, r};
    endfunction

    function automatic logic is_legal(input logic [3:0] o);
        return (o <= 4'd7) || (o == 4'd13) || (o == 4'd14);
    endfunction

    always_comb {ULA_flags, ULA_OUT} = ula_f(ULA_ctrl, ULA_A, ULA_B, incdec);

    task automatic do_load(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        R[a] = d;
    endtask

    // Issues one instruction and checks it through retirement; optionally
    // drives the load port on the writeback edge.
    task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic inc, input logic coll,
                         input logic [2:0] caddr, input logic [W-1:0] cdata);
        logic [W-1:0] ea, eb, eres;
        logic [2:0]   ef;
        logic         einc, leg;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL ready_idle got=%b exp=1", instr_ready); end
        ea = R[s1]; eb = R[s2];
        einc = (o == 4'd0 || o == 4'd1) ? inc : 1'b0;
        {ef, eres} = ula_f(o, ea, eb, einc);
        leg = is_legal(o);
        instr_valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; inc_in = inc;
        @(posedge clk); #1;
        // garbage on non-load inputs while busy must be ignored
        instr_valid = 1'($urandom_range(0, 1)); op = 4'($urandom); rd = 3'($urandom);
        rs1 = 3'($urandom); rs2 = 3'($urandom); inc_in = 1'($urandom);
        checks++; if (ULA_A !== ea) begin failures++; $display("FAIL ula_a got=%h exp=%h", ULA_A, ea); end
        checks++; if (ULA_B !== eb) begin failures++; $display("FAIL ula_b got=%h exp=%h", ULA_B, eb); end
        checks++; if (ULA_ctrl !== o) begin failures++; $display("FAIL ula_ctrl got=%h exp=%h", ULA_ctrl, o); end
        checks++; if (incdec !== einc) begin failures++; $display("FAIL incdec got=%b exp=%b", incdec, einc); end
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL ready_exec got=%b exp=0", instr_ready); end
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL ready_wb got=%b exp=0", instr_ready); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL wb_early got=%b exp=0", wb_valid); end
        checks++; if (ULA_A !== ea || ULA_ctrl !== o) begin failures++; $display("FAIL ula_hold got=%h/%h exp=%h/%h", ULA_A, ULA_ctrl, ea, o); end
        if (coll) begin ld_en = 1'b1; ld_addr = caddr; ld_data = cdata; end
        @(posedge clk); #1;
        ld_en = 1'b0; instr_valid = 1'b0;
        if (coll) R[caddr] = cdata;
        if (leg) begin R[d] = eres; mflags = ef; end
        checks++; if (wb_valid !== leg) begin failures++; $display("FAIL wb_valid got=%b exp=%b", wb_valid, leg); end
        checks++; if (op_err !== !leg) begin failures++; $display("FAIL op_err got=%b exp=%b", op_err, !leg); end
        checks++; if (flags !== mflags) begin failures++; $display("FAIL flags got=%b exp=%b", flags, mflags); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL ready_back got=%b exp=1", instr_ready); end
        for (int i = 0; i < 8; i++) begin
            obs_addr = 3'(i); #1;
            checks++; if (obs_data !== R[i]) begin failures++; $display("FAIL reg%0d got=%h exp=%h", i, obs_data, R[i]); end
        end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0 || op_err !== 1'b0) begin failures++; $display("FAIL pulse_len got=%b%b exp=00", wb_valid, op_err); end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        inc_in = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; obs_addr = '0;
        #2 rst = 1'b0;
        #2;
        for (int i = 0; i < 8; i++) R[i] = '0;
        mflags = '0;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        checks++; if (ULA_A !== '0 || ULA_B !== '0) begin failures++; $display("FAIL rst_ops got=%h/%h exp=0/0", ULA_A, ULA_B); end
        checks++; if (ULA_ctrl !== 4'd0 || incdec !== 1'b0) begin failures++; $display("FAIL rst_ctrl got=%h/%b exp=0/0", ULA_ctrl, incdec); end
        checks++; if (flags !== 3'b000 || wb_valid !== 1'b0 || op_err !== 1'b0) begin failures++; $display("FAIL rst_out got=%b%b%b exp=00000", flags, wb_valid, op_err); end
        for (int i = 0; i < 8; i++) begin
            obs_addr = 3'(i); #1;
            checks++; if (obs_data !== '0) begin failures++; $display("FAIL rst_reg%0d got=%h exp=0", i, obs_data); end
        end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%b exp=1", instr_ready); end
    endtask

    task automatic test_add();
        do_load(3'd1, 16'h0005);
        do_load(3'd2, 16'h0003);
        issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, '0);
        checks++; if (R[3] !== 16'h0008 || mflags !== 3'b000) begin failures++; $display("FAIL add_model got=%h/%b exp=0008/000", R[3], mflags); end
    endtask

    task automatic test_sub();
        do_load(3'd1, 16'h0003);
        do_load(3'd2, 16'h0005);
        issue(4'd1, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, '0);
        checks++; if (R[4] !== 16'hFFFE || mflags[2:1] !== 2'b10) begin failures++; $display("FAIL sub_model got=%h/%b exp=FFFE/10x", R[4], mflags); end
    endtask

    task automatic test_incdec();
        do_load(3'd1, 16'h00FF);
        issue(4'd0, 3'd5, 3'd1, 3'd0, 1'b1, 1'b0, 3'd0, '0);
        issue(4'd2, 3'd6, 3'd1, 3'd1, 1'b1, 1'b0, 3'd0, '0);
    endtask

    task automatic test_illegal();
        issue(4'd4, 3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, '0);
        checks++; if (mflags !== 3'b010) begin failures++; $display("FAIL zero_setup got=%b exp=010", mflags); end
        issue(4'd8, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, '0);
    endtask

    task automatic test_wb_collision();
        do_load(3'd1, 16'h0005);
        do_load(3'd2, 16'h0003);
        issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 3'd3, 16'h1234);
        checks++; if (R[3] !== 16'h0008) begin failures++; $display("FAIL coll_model got=%h exp=0008", R[3]); end
    endtask

    task automatic test_reset_mid(input int stage);
        do_load(3'd1, 16'h8001);
        do_load(3'd2, 16'h0002);
        @(negedge clk);
        instr_valid = 1'b1; op = 4'd0; rd = 3'd7; rs1 = 3'd1; rs2 = 3'd2; inc_in = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (stage == 2) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) R[i] = '0;
        mflags = '0;
        checks++; if (instr_ready !== 1'b1 || ULA_A !== '0) begin failures++; $display("FAIL midrst_%0d got=%b/%h exp=1/0", stage, instr_ready, ULA_A); end
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", instr_ready); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (wb_valid !== 1'b0 || flags !== 3'b000) begin failures++; $display("FAIL midrst_wb got=%b/%b exp=0/000", wb_valid, flags); end
        end
        obs_addr = 3'd7; #1;
        checks++; if (obs_data !== '0) begin failures++; $display("FAIL midrst_rd got=%h exp=0", obs_data); end
    endtask

    task automatic test_back_to_back();
        int hs [$];
        int wbcnt;
        wbcnt = 0;
        do_load(3'd5, 16'h0001);
        do_load(3'd6, 16'h0002);
        @(negedge clk);
        instr_valid = 1'b1; op = 4'd0; rd = 3'd5; rs1 = 3'd5; rs2 = 3'd6; inc_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (instr_ready) begin
                hs.push_back(c);
                {mflags, R[5]} = ula_f(4'd0, R[5], R[6], 1'b0);
            end
            @(posedge clk); #1;
            if (wb_valid) wbcnt++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++; if (hs.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", hs.size()); end
        for (int k = 0; k < hs.size(); k++) begin
            checks++; if (hs[k] != 3 * k) begin failures++; $display("FAIL b2b_slot%0d got=%0d exp=%0d", k, hs[k], 3 * k); end
        end
        checks++; if (wbcnt != hs.size()) begin failures++; $display("FAIL b2b_wb got=%0d exp=%0d", wbcnt, hs.size()); end
        obs_addr = 3'd5; #1;
        checks++; if (obs_data !== R[5]) begin failures++; $display("FAIL b2b_r5 got=%h exp=%h", obs_data, R[5]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int nl;
            nl = $urandom_range(0, 2);
            for (int j = 0; j < nl; j++) do_load(3'($urandom), 16'($urandom));
            issue(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 3'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_incdec();
        test_illegal();
        test_wb_collision();
        test_reset_mid(1);
        test_reset_mid(2);
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
